// File: rtl/axil_ram_pkg.sv
// Shared types, response codes and memory map for the AXI4-Lite RAM bridge.
// Instruction region is read-only; the data region accepts full-word writes.
package axil_ram_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_MEM,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_MEM,
        R_RESP
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int IMEM_BASE = 'h0;
    localparam int DMEM_BASE = 'h800;
    localparam int MEM_BYTES = 'h1000;

    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (addr >= lo) && (addr < hi);
    endfunction

endpackage

// File: rtl/axil_ram_rd_ch.sv
// AXI4-Lite read channel: one AR per three cycles, one-cycle RAM read strobe.
// Read data is passed through from the RAM, which holds it until the handshake.
module axil_ram_rd_ch #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = axil_ram_pkg::MEM_BYTES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] s_araddr_i,
    input  logic              s_arvalid_i,
    output logic              s_arready_o,
    output logic [DATA_W-1:0] s_rdata_o,
    output logic [1:0]        s_rresp_o,
    output logic              s_rvalid_o,
    input  logic              s_rready_i,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic              ram_re_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    import axil_ram_pkg::*;

    rd_state_t         r_state;
    logic              r_arready;
    logic              r_rvalid;
    logic [1:0]        r_rresp;
    logic              r_re;
    logic [ADDR_W-1:0] r_raddr;
    logic              w_ar_hs;
    logic              w_rd_ok;

    assign w_ar_hs = s_arvalid_i && r_arready;
    assign w_rd_ok = addr_in_range(s_araddr_i, IMEM_BASE, MEM_BYTES)
                  && (s_araddr_i[1:0] == 2'b00);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_re      <= 1'b0;
            r_raddr   <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_state   <= R_MEM;
                        r_arready <= 1'b0;
                        r_raddr   <= s_araddr_i;
                        r_re      <= w_rd_ok;
                        r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_MEM: begin
                    r_re     <= 1'b0;
                    r_rvalid <= 1'b1;
                    r_state  <= R_RESP;
                end
                R_RESP: begin
                    if (s_rready_i) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s_arready_o = r_arready;
    assign s_rvalid_o  = r_rvalid;
    assign s_rresp_o   = r_rresp;
    assign s_rdata_o   = (r_rvalid && r_rresp == RESP_OKAY) ? ram_rdata_i : '0;
    assign ram_raddr_o = r_raddr;
    assign ram_re_o    = r_re;

endmodule

// File: rtl/axil_ram_bridge.sv
// AXI4-Lite slave in front of a 4 KB simple-dual-port RAM.
// Write FSM lives here; the independent read FSM is in axil_ram_rd_ch.
module axil_ram_bridge #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = axil_ram_pkg::MEM_BYTES,
    parameter int DMEM_BASE = axil_ram_pkg::DMEM_BASE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] s_awaddr_i,
    input  logic              s_awvalid_i,
    output logic              s_awready_o,
    input  logic [DATA_W-1:0] s_wdata_i,
    input  logic [3:0]        s_wstrb_i,
    input  logic              s_wvalid_i,
    output logic              s_wready_o,
    output logic [1:0]        s_bresp_o,
    output logic              s_bvalid_o,
    input  logic              s_bready_i,
    input  logic [ADDR_W-1:0] s_araddr_i,
    input  logic              s_arvalid_i,
    output logic              s_arready_o,
    output logic [DATA_W-1:0] s_rdata_o,
    output logic [1:0]        s_rresp_o,
    output logic              s_rvalid_o,
    input  logic              s_rready_i,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic              ram_re_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    import axil_ram_pkg::*;

    wr_state_t         r_wstate;
    logic              r_awready;
    logic              r_wready;
    logic              r_aw_got;
    logic              r_w_got;
    logic [ADDR_W-1:0] r_awaddr;
    logic [DATA_W-1:0] r_wbuf;
    logic [3:0]        r_wstrb;
    logic              r_we;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_aw_have;
    logic              w_w_have;
    logic [ADDR_W-1:0] w_aw_addr;
    logic [3:0]        w_wstrb;
    logic              w_wr_ok;

    assign w_aw_hs   = s_awvalid_i && r_awready;
    assign w_w_hs    = s_wvalid_i && r_wready;
    assign w_aw_have = r_aw_got || w_aw_hs;
    assign w_w_have  = r_w_got || w_w_hs;
    assign w_aw_addr = w_aw_hs ? s_awaddr_i : r_awaddr;
    assign w_wstrb   = w_w_hs ? s_wstrb_i : r_wstrb;

    // Decide legality at the IDLE exit so the strobe can be registered.
    assign w_wr_ok = addr_in_range(w_aw_addr, DMEM_BASE, MEM_BYTES)
                  && (w_aw_addr[1:0] == 2'b00)
                  && (w_wstrb == 4'hF);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awaddr  <= '0;
            r_wbuf    <= '0;
            r_wstrb   <= '0;
            r_we      <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr <= s_awaddr_i;
                        r_aw_got <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wbuf  <= s_wdata_i;
                        r_wstrb <= s_wstrb_i;
                        r_w_got <= 1'b1;
                    end
                    if (w_aw_have && w_w_have) begin
                        r_wstate  <= W_MEM;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_got  <= 1'b0;
                        r_w_got   <= 1'b0;
                        r_we      <= w_wr_ok;
                        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_awready <= !w_aw_have;
                        r_wready  <= !w_w_have;
                    end
                end
                W_MEM: begin
                    r_we     <= 1'b0;
                    r_bvalid <= 1'b1;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (s_bready_i) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign s_awready_o = r_awready;
    assign s_wready_o  = r_wready;
    assign s_bvalid_o  = r_bvalid;
    assign s_bresp_o   = r_bresp;
    assign ram_waddr_o = r_awaddr;
    assign ram_wdata_o = r_wbuf;
    assign ram_we_o    = r_we;
    assign ram_cs_o    = r_we || ram_re_o;

    axil_ram_rd_ch #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_rd_ch (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .s_araddr_i  (s_araddr_i),
        .s_arvalid_i (s_arvalid_i),
        .s_arready_o (s_arready_o),
        .s_rdata_o   (s_rdata_o),
        .s_rresp_o   (s_rresp_o),
        .s_rvalid_o  (s_rvalid_o),
        .s_rready_i  (s_rready_i),
        .ram_raddr_o (ram_raddr_o),
        .ram_re_o    (ram_re_o),
        .ram_rdata_i (ram_rdata_i)
    );

endmodule

// File: doc/axil_ram_bridge.md
# axil_ram_bridge

AXI4-Lite slave that sits directly upstream of the 4 KB simple-dual-port RAM and translates bus transactions into its native strobes. The native strobes are chip-select, read-enable, write-enable and separate read/write addresses, with one-cycle registered read data. Reads may target the whole map (instruction region 0x000–0x7FF, data region 0x800–0xFFF); writes are legal only in the data region. Read and write channels run independently, so one read and one write may hit the RAM in the same cycle.

## Interface
- ADDR_W, 32, AXI and RAM address width
- DATA_W, 32, data width; fixed 32, RAM has no byte enables
- MEM_BYTES, 4096, total mapped size
- DMEM_BASE, 2048, first writable byte address
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- s_awaddr_i / s_awvalid_i / s_awready_o  in/in/out  32/1/1  write address channel
- s_wdata_i / s_wstrb_i / s_wvalid_i / s_wready_o  in/in/in/out  32/4/1/1  write data channel
- s_bresp_o / s_bvalid_o / s_bready_i  out/out/in  2/1/1  write response
- s_araddr_i / s_arvalid_i / s_arready_o  in/in/out  32/1/1  read address channel
- s_rdata_o / s_rresp_o / s_rvalid_o / s_rready_i  out/out/out/in  32/2/1/1  read response
- ram_waddr_o  out  32  byte write address to RAM
- ram_raddr_o  out  32  byte read address to RAM
- ram_wdata_o  out  32  write data to RAM
- ram_cs_o  out  1  asserted when ram_we_o or ram_re_o is high
- ram_we_o  out  1  one-cycle write strobe
- ram_re_o  out  1  one-cycle read strobe
- ram_rdata_i  in  32  RAM read data, valid the cycle after ram_re_o

## Operation
- Write FSM: W_IDLE -> W_MEM -> W_RESP -> W_IDLE.
  - W_IDLE: s_awready_o and s_wready_o high. AW and W may complete in either order or together; each is latched once. Leave W_IDLE only when both are held.
  - W_MEM: if address in [DMEM_BASE, MEM_BYTES), word-aligned, and wstrb == 4'hF, pulse ram_we_o with latched addr/data and set resp OKAY (2'b00). Otherwise no strobe, resp SLVERR (2'b10).
  - W_RESP: s_bvalid_o high until s_bready_i.
- Read FSM: R_IDLE -> R_MEM -> R_RESP -> R_IDLE.
  - R_IDLE: s_arready_o high.
  - R_MEM: if address < MEM_BYTES and word-aligned, pulse ram_re_o with the latched address. Otherwise no strobe, resp SLVERR.
  - R_RESP: s_rvalid_o high. s_rdata_o = ram_rdata_i on OKAY, 0 on SLVERR. The RAM holds its output because no further ram_re_o is issued until the handshake.
- Same-cycle read and write to the same word: the read returns the old data.
- Upper address bits [31:12] nonzero: SLVERR on both channels.

## Timing
- Reset values: all ready/valid outputs 0 while rst_i is high. IDLE readies rise the first cycle after release. bresp, rresp, rdata, ram_* addr/data, and all strobes are 0.
- Write: last of AW/W handshake in cycle N -> ram_we_o in N+1 -> s_bvalid_o from N+2.
- Read: AR handshake in cycle N -> ram_re_o in N+1 -> s_rvalid_o with data from N+2.
- Error paths use the same latency, with no RAM strobe.
- Throughput: one transaction per channel per 3 cycles when ready/bready are tied high.
- Backpressure: bvalid/rvalid and their payloads are held stable until the handshake. No new AW/W/AR is accepted meanwhile.
- Reset mid-transaction: both FSMs return to IDLE immediately, the pending response is dropped, and no strobe is issued. RAM contents are not touched by the bridge.

## Structure
- Package axil_ram_pkg holds:
  - wr_state_t and rd_state_t enums
  - RESP_OKAY and RESP_SLVERR
  - IMEM_BASE = 0, DMEM_BASE = 'h800, MEM_BYTES = 'h1000
  - an addr_in_range helper function
- One natural sub-module: axil_ram_rd_ch (the read FSM), instantiated beside the inline write FSM.

## Test plan
- Write 0xDEADBEEF to 0x800 (AW before W), then read 0x800 -> bresp 0, ram_we_o one cycle with waddr 0x800, rdata 0xDEADBEEF with rresp 0.
- Write to 0x100 with W arriving 3 cycles before AW -> bresp 2'b10, ram_we_o never asserted.
- Write 0x800 with wstrb 4'h3; write 0x802 -> both return SLVERR with no strobe. Read 0x1000 -> rresp 2'b10, rdata 0.
- Read 0x004 while simultaneously writing 0x004-equivalent data word 0x804 with 0x12345678 -> ram_re_o and ram_we_o in the same cycle with ram_cs_o high, both responses OKAY.
- Hold s_rready_i low for 5 cycles after rvalid -> rdata/rresp stable, s_arready_o low until the handshake.
- Assert rst_i while in R_MEM / W_RESP -> all valids and strobes 0 asynchronously. After release, a new read to 0x808 completes with 2-cycle latency.
